// File: rtl/pipe_hazard_ctrl.sv
// RISC15 pipeline control: branch flush, load-use stall and LM/SM micro-op sequencing.
// The LM/SM sequencer is built only when PIPE_HAZARD_CTRL_LMSM_EN is defined.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir_id,
    input  logic        src_a_vld,
    input  logic [2:0]  src_a,
    input  logic        src_b_vld,
    input  logic [2:0]  src_b,
    input  logic        ex_load,
    input  logic [2:0]  ex_dest,
    input  logic        br_taken,
    output logic        pc_hold,
    output logic        ir_hold,
    output logic        flush,
    output logic        bubble,
    output logic        seq_valid,
    output logic        seq_store,
    output logic [2:0]  seq_reg,
    output logic [2:0]  seq_offset,
    output logic        seq_last
);
    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    logic load_use;
    logic pc_hold_c, ir_hold_c, flush_c, bubble_c;
    logic seq_valid_c, seq_store_c, seq_last_c;
    logic [2:0] seq_reg_c, seq_offset_c;
    logic unused_bits;

    assign unused_bits = &{1'b0, ir_id};

    assign load_use = ex_load && ((src_a_vld && (src_a == ex_dest)) ||
                                  (src_b_vld && (src_b == ex_dest)));

`ifdef PIPE_HAZARD_CTRL_LMSM_EN
    typedef enum logic {IDLE, SEQ} state_t;

    state_t     state_reg, state_next;
    logic [7:0] mask_reg, mask_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       store_reg, store_next;
    logic       is_lmsm, is_sm;
    logic [7:0] src_list, rem_list;
    logic [2:0] sel;

    // Fixed priority encoder: scanning downward lets the lowest set bit win.
    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign is_sm    = (ir_id[15:12] == OP_SM);
    assign is_lmsm  = (ir_id[15:12] == OP_LM) || is_sm;
    assign src_list = (state_reg == SEQ) ? mask_reg : ir_id[7:0];
    assign sel      = lowest_bit(src_list);
    assign rem_list = src_list & ~(8'd1 << sel);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            mask_reg  <= 8'd0;
            cnt_reg   <= 3'd0;
            store_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            mask_reg  <= mask_next;
            cnt_reg   <= cnt_next;
            store_reg <= store_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        mask_next    = mask_reg;
        cnt_next     = cnt_reg;
        store_next   = store_reg;
        pc_hold_c    = 1'b0;
        ir_hold_c    = 1'b0;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        seq_valid_c  = 1'b0;
        seq_store_c  = 1'b0;
        seq_reg_c    = 3'd0;
        seq_offset_c = 3'd0;
        seq_last_c   = 1'b0;

        if (br_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (state_reg == SEQ) begin
                mask_next  = 8'd0;
                cnt_next   = 3'd0;
                state_next = IDLE;
            end
        end else if (state_reg == IDLE) begin
            if (load_use) begin
                pc_hold_c = 1'b1;
                ir_hold_c = 1'b1;
                bubble_c  = 1'b1;
            end else if (is_lmsm) begin
                if (ir_id[7:0] != 8'd0) begin
                    seq_valid_c  = 1'b1;
                    seq_reg_c    = sel;
                    seq_store_c  = is_sm;
                    mask_next    = rem_list;
                    cnt_next     = 3'd1;
                    store_next   = is_sm;
                    if (rem_list != 8'd0) begin
                        pc_hold_c  = 1'b1;
                        ir_hold_c  = 1'b1;
                        state_next = SEQ;
                    end else begin
                        seq_last_c = 1'b1;
                    end
                end else begin
                    // Empty register list does no work; squash it.
                    bubble_c = 1'b1;
                end
            end
        end else begin
            seq_valid_c  = 1'b1;
            seq_reg_c    = sel;
            seq_offset_c = cnt_reg;
            seq_store_c  = store_reg;
            mask_next    = rem_list;
            cnt_next     = cnt_reg + 3'd1;
            if (rem_list == 8'd0) begin
                seq_last_c = 1'b1;
                state_next = IDLE;
            end else begin
                pc_hold_c = 1'b1;
                ir_hold_c = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pc_hold_c    = 1'b0;
        ir_hold_c    = 1'b0;
        flush_c      = 1'b0;
        bubble_c     = 1'b0;
        seq_valid_c  = 1'b0;
        seq_store_c  = 1'b0;
        seq_reg_c    = 3'd0;
        seq_offset_c = 3'd0;
        seq_last_c   = 1'b0;
        if (br_taken) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
        end else if (load_use) begin
            pc_hold_c = 1'b1;
            ir_hold_c = 1'b1;
            bubble_c  = 1'b1;
        end
    end
`endif

    // Outputs are forced low while reset is asserted, whatever the inputs say.
    assign pc_hold    = reset & pc_hold_c;
    assign ir_hold    = reset & ir_hold_c;
    assign flush      = reset & flush_c;
    assign bubble     = reset & bubble_c;
    assign seq_valid  = reset & seq_valid_c;
    assign seq_store  = reset & seq_store_c;
    assign seq_reg    = reset ? seq_reg_c : 3'd0;
    assign seq_offset = reset ? seq_offset_c : 3'd0;
    assign seq_last   = reset & seq_last_c;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the RISC15 five-stage pipeline. It drives the hold and flush controls of the IF/ID pipeline register and the PC, and inserts bubbles into ID/EX. It also sequences load-multiple/store-multiple (LM/SM) instructions held in the decode stage into one micro-op per register. Sits beside the decoder and consumes the IF/ID instruction, EX-stage load information and the EX-stage branch resolution.

## Interface
- OP_LM, 4'b0110, opcode of load-multiple (ir_id[15:12]).
- OP_SM, 4'b0111, opcode of store-multiple.

- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ir_id  in  16  instruction currently in IF/ID; register list is ir_id[7:0].
- src_a_vld / src_a  in  1 / 3  decoder: instruction in ID reads register src_a.
- src_b_vld / src_b  in  1 / 3  decoder: instruction in ID reads register src_b.
- ex_load  in  1  instruction in EX is a load (LW or LM micro-op).
- ex_dest  in  3  destination register of the EX instruction.
- br_taken  in  1  EX-stage branch/jump redirect this cycle.
- pc_hold  out  1  1 = PC keeps its value.
- ir_hold  out  1  1 = IF/ID keeps its instruction.
- flush  out  1  1 = IF/ID loads NOP (16'hF000) next edge.
- bubble  out  1  1 = ID/EX loads NOP instead of the decoded instruction.
- seq_valid  out  1  an LM/SM micro-op is issued this cycle.
- seq_store  out  1  1 = SM micro-op, 0 = LM micro-op.
- seq_reg  out  3  register index for this micro-op.
- seq_offset  out  3  word offset from base, 0..7.
- seq_last  out  1  final micro-op of the current LM/SM.

## Operation
- State: IDLE, SEQ. Registers: mask[7:0] (remaining list bits), cnt[2:0] (next offset), store flag.
- Outputs are combinational from state, registers and inputs. State updates on the rising clk edge.
- Priority each cycle: flush > load-use stall > LM/SM sequencing.
- Flush:
  - br_taken=1 gives flush=1 and bubble=1, with pc_hold=0 and ir_hold=0.
  - In SEQ, it aborts the sequence: mask<=0, cnt<=0, next state IDLE, seq_valid=0.
- Load-use (IDLE only):
  - Condition: ex_load && ((src_a_vld && src_a==ex_dest) || (src_b_vld && src_b==ex_dest)).
  - Response: pc_hold=1, ir_hold=1, bubble=1, seq_valid=0, state unchanged.
  - For LM/SM, the base register is reported on src_a, so the stall precedes sequence start.
- IDLE, opcode LM/SM, list nonzero:
  - seq_valid=1; seq_reg = index of the lowest set bit of ir_id[7:0]; seq_offset=0.
  - seq_store=(opcode==OP_SM).
  - Load mask with the list minus that bit, cnt<=1, latch the store flag.
  - If the remaining mask is nonzero: pc_hold=ir_hold=1, seq_last=0, go SEQ.
  - Otherwise: seq_last=1, no holds, stay IDLE.
- IDLE, opcode LM/SM, list zero: bubble=1, no micro-op, no hold.
- SEQ:
  - seq_valid=1; seq_reg = lowest set bit of mask; seq_offset=cnt; seq_store=latched flag.
  - Clear that bit and increment cnt.
  - If it was the last bit: seq_last=1, holds released, go IDLE.
  - Otherwise: pc_hold=ir_hold=1.
- Load-use is not evaluated in SEQ. The EX/MEM forwarding path covers micro-op dependencies.
- Lowest-set-bit selection is a fixed priority encoder, bit 0 first.

## Timing
- Reset (reset=0): state IDLE, mask=0, cnt=0, store=0. All outputs 0 regardless of inputs, including seq_reg=0 and seq_offset=0.
- An LM/SM with N set bits issues N micro-ops on N consecutive cycles, with N-1 hold cycles.
- The next instruction enters ID on the edge after seq_last.
- Load-use stall lasts exactly one cycle, because the load leaves EX.
- flush and bubble take effect at the next edge. flush and hold are never asserted together.
- Reset asserted mid-sequence returns to IDLE immediately (asynchronously) with all outputs 0.
- cnt wraps only after 8 micro-ops (full list 8'hFF), which coincides with seq_last.

## Configuration
- PIPE_HAZARD_CTRL_LMSM_EN defined: LM/SM sequencer built as described.
- Not defined:
  - SEQ state, mask, cnt and the priority encoder are removed.
  - seq_valid, seq_store, seq_reg, seq_offset and seq_last are tied to 0.
  - LM/SM are treated as ordinary instructions: no holds apart from load-use.
  - Flush and load-use behaviour are unchanged.

## Test plan
- Reset with br_taken=1 and ex_load=1 matching src_a -> all outputs 0. After release, outputs follow inputs the same cycle.
- ex_load=1, ex_dest=3, src_b_vld=1, src_b=3 -> one cycle of pc_hold=ir_hold=bubble=1, then outputs 0 once ex_load=0.
- LM with list 8'b00010110 -> seq_reg 1,2,4 with offsets 0,1,2 on three cycles. Holds on the first two cycles; seq_last on the third; seq_store=0.
- SM with list 8'h80 -> one cycle: seq_reg=7, seq_offset=0, seq_last=1, seq_store=1, no hold.
- LM with list 8'hFF, br_taken=1 on the 3rd micro-op cycle -> flush=1, bubble=1, seq_valid=0. Next cycle state IDLE and a new LM restarts at offset 0.
- LM with list 8'h00 -> bubble=1, seq_valid=0, no hold. With the macro undefined, LM 8'hFF -> no holds, seq_valid=0.
